// File: rtl/ras_ckpt_queue_pkg.sv
// Shared frontend definitions for the RAS checkpoint queue: the RAS redirect
// snapshot type, the {dir, idx} queue pointer type and wrapping pointer helpers.
package ras_ckpt_queue_pkg;

  localparam int FSQ_SIZE        = 32;
  localparam int RAS_CKPT_DEPTH  = FSQ_SIZE;
  localparam int RAS_CKPT_IDX_W  = $clog2(RAS_CKPT_DEPTH);
  localparam int RAS_STACK_PTR_W = 5;

  // Speculative RAS state captured per predicted block.
  typedef struct packed {
    logic [RAS_STACK_PTR_W-1:0] rasTop;
    logic [RAS_STACK_PTR_W-1:0] listTop;
    logic [RAS_STACK_PTR_W-1:0] inflightTop;
    logic                       topInvalid;
  } RasRedirectInfo;

  localparam int RAS_INFO_W = $bits(RasRedirectInfo);

  // Queue pointer: the dir bit flips each time idx wraps past DEPTH-1.
  typedef struct packed {
    logic                      dir;
    logic [RAS_CKPT_IDX_W-1:0] idx;
  } RasCkptIdx;

  // Pointer increment, wrapping modulo 2*DEPTH.
  function automatic RasCkptIdx ptr_inc(input RasCkptIdx p);
    logic [RAS_CKPT_IDX_W:0] s;
    s = p + 1'b1;
    return s;
  endfunction

  // Pointer distance a - b, modulo 2*DEPTH.
  function automatic logic [RAS_CKPT_IDX_W:0] ptr_sub(input RasCkptIdx a,
                                                      input RasCkptIdx b);
    return a - b;
  endfunction

endpackage

// File: rtl/ras_ckpt_queue_mem.sv
// Checkpoint storage: one write port, one asynchronous read port, no reset
// on the array contents.
module ras_ckpt_queue_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the allocated checkpoint into its slot.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ras_ckpt_queue.sv
// Per-FSQ-entry checkpoint queue for RAS speculative state. Entries are
// allocated at the tail, read back and rolled back on a redirect, and freed
// at the head on commit. Optional macro RAS_CKPT_PARITY_EN adds an even
// parity bit per entry and the sq_perr output.
module ras_ckpt_queue
  import ras_ckpt_queue_pkg::*;
#(
  parameter int DEPTH  = RAS_CKPT_DEPTH,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int INFO_W = $bits(RasRedirectInfo)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enq_valid,
  input  logic [INFO_W-1:0] enq_info,
  output logic              enq_ready,
  output logic [IDX_W:0]    enq_idx,
  input  logic              sq_valid,
  input  logic [IDX_W:0]    sq_idx,
  output logic              sq_info_valid,
  output logic [INFO_W-1:0] sq_info,
  output logic              sq_err,
  input  logic              cm_valid,
`ifdef RAS_CKPT_PARITY_EN
  output logic              sq_perr,
`endif
  output logic [IDX_W:0]    count
);

`ifdef RAS_CKPT_PARITY_EN
  localparam int MEM_W = INFO_W + 1;
`else
  localparam int MEM_W = INFO_W;
`endif

  RasCkptIdx         head_q, head_d, tail_q, tail_d, sq_ptr;
  logic [IDX_W:0]    occ, sq_off;
  logic              empty, full, enq_fire, sq_hit, cm_fire;
  logic [MEM_W-1:0]  wr_word, rd_word;
  logic              sq_info_valid_q, sq_err_q;
  logic [INFO_W-1:0] sq_info_q;

  assign sq_ptr   = sq_idx;
  assign occ      = ptr_sub(tail_q, head_q);
  assign empty    = (head_q == tail_q);
  assign full     = (head_q.idx == tail_q.idx) && (head_q.dir != tail_q.dir);
  // Squash window check is against the pre-commit head.
  assign sq_off   = ptr_sub(sq_ptr, head_q);
  assign sq_hit   = sq_valid && (sq_off < occ);
  assign enq_ready = !full && !sq_valid;
  assign enq_fire = enq_valid && enq_ready;
  assign cm_fire  = cm_valid && !empty;

`ifdef RAS_CKPT_PARITY_EN
  assign wr_word = {^enq_info, enq_info};
`else
  assign wr_word = enq_info;
`endif

  ras_ckpt_queue_mem #(
    .WIDTH (MEM_W),
    .DEPTH (DEPTH),
    .AW    (IDX_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (enq_fire),
    .waddr_i (tail_q.idx),
    .wdata_i (wr_word),
    .raddr_i (sq_ptr.idx),
    .rdata_o (rd_word)
  );

  // Pointer next-state: a squash truncates the tail, a commit frees the head.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (sq_hit)        tail_d = ptr_inc(sq_ptr);
    else if (enq_fire) tail_d = ptr_inc(tail_q);
    if (cm_fire)       head_d = ptr_inc(head_q);
  end

  // Pointers, squash read register and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q          <= '0;
      tail_q          <= '0;
      sq_info_valid_q <= 1'b0;
      sq_info_q       <= '0;
      sq_err_q        <= 1'b0;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      sq_info_valid_q <= sq_hit;
      if (sq_hit) sq_info_q <= rd_word[INFO_W-1:0];
      if (sq_valid && !sq_hit) sq_err_q <= 1'b1;
    end
  end

`ifdef RAS_CKPT_PARITY_EN
  logic sq_perr_q;

  // Parity check on the squash read, pulsed alongside sq_info_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sq_perr_q <= 1'b0;
    else     sq_perr_q <= sq_hit && (^rd_word);
  end

  assign sq_perr = sq_perr_q;
`endif

  assign enq_idx       = tail_q;
  assign count         = occ;
  assign sq_info_valid = sq_info_valid_q;
  assign sq_info       = sq_info_q;
  assign sq_err        = sq_err_q;

endmodule

// File: tb/tb_ras_ckpt_queue.sv
// Scoreboard bench for ras_ckpt_queue: directed scenarios plus random traffic
// against a queue/array model; a monitor pops expectations each cycle.
module tb_ras_ckpt_queue;
  import ras_ckpt_queue_pkg::*;

  localparam int D  = RAS_CKPT_DEPTH;
  localparam int IW = RAS_INFO_W;
  localparam int PW = RAS_CKPT_IDX_W + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enq_valid = 1'b0;
  logic [IW-1:0] enq_info = '0;
  logic          enq_ready;
  logic [PW-1:0] enq_idx;
  logic          sq_valid = 1'b0;
  logic [PW-1:0] sq_idx = '0;
  logic          sq_info_valid;
  logic [IW-1:0] sq_info;
  logic          sq_err;
  logic          cm_valid = 1'b0;
  logic [PW-1:0] count;
`ifdef RAS_CKPT_PARITY_EN
  logic          sq_perr;
`endif

  ras_ckpt_queue dut (
    .clk           (clk),
    .rst           (rst),
    .enq_valid     (enq_valid),
    .enq_info      (enq_info),
    .enq_ready     (enq_ready),
    .enq_idx       (enq_idx),
    .sq_valid      (sq_valid),
    .sq_idx        (sq_idx),
    .sq_info_valid (sq_info_valid),
    .sq_info       (sq_info),
    .sq_err        (sq_err),
    .cm_valid      (cm_valid),
`ifdef RAS_CKPT_PARITY_EN
    .sq_perr       (sq_perr),
`endif
    .count         (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int idx;
    bit rdy;
    bit err;
    bit sqv;
    bit perr;
  } rec_t;

  rec_t          rec_q[$];
  logic [IW-1:0] info_q[$];
  int            errors = 0;
  int            checks = 0;

  // Reference model: pointers as integers modulo 2*D, contents per slot.
  int            m_head, m_tail;
  bit            m_err;
  logic [IW-1:0] m_mem [D];
  bit            m_flip [D];

  function automatic int mcnt();
    return (m_tail - m_head + 2 * D) % (2 * D);
  endfunction

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // One clock of stimulus; the model predicts the state after the next edge.
  task automatic cyc(input bit ev, input logic [IW-1:0] info, input bit sv,
                     input int si, input bit cv);
    rec_t r;
    int   cnt, nt;
    @(negedge clk);
    enq_valid = ev;
    enq_info  = info;
    sq_valid  = sv;
    sq_idx    = si[PW-1:0];
    cm_valid  = cv;
    cnt    = mcnt();
    nt     = m_tail;
    r.sqv  = 1'b0;
    r.perr = 1'b0;
    if (sv) begin
      if (((si - m_head + 2 * D) % (2 * D)) < cnt) begin
        r.sqv  = 1'b1;
        r.perr = m_flip[si % D];
        info_q.push_back(m_mem[si % D]);
        nt = (si + 1) % (2 * D);
      end else begin
        m_err = 1'b1;
      end
    end else if (ev && cnt < D) begin
      m_mem[m_tail % D]  = info;
      m_flip[m_tail % D] = 1'b0;
      nt = (m_tail + 1) % (2 * D);
    end
    if (cv && cnt > 0) m_head = (m_head + 1) % (2 * D);
    m_tail = nt;
    r.cnt = mcnt();
    r.idx = m_tail;
    r.rdy = (r.cnt < D) && !sv;
    r.err = m_err;
    rec_q.push_back(r);
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 0, 1'b0);
  endtask

  task automatic enq(input logic [IW-1:0] info);
    cyc(1'b1, info, 1'b0, 0, 1'b0);
  endtask

  // Wait until the last driven edge has been checked by the monitor.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_dut();
    settle();
    rst = 1'b1;
    enq_valid = 1'b0;
    sq_valid  = 1'b0;
    cm_valid  = 1'b0;
    m_head = 0;
    m_tail = 0;
    m_err  = 1'b0;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_enq_ready", int'(enq_ready), 1);
    chk("rst_enq_idx", int'(enq_idx), 0);
    chk("rst_sq_info_valid", int'(sq_info_valid), 0);
    chk("rst_sq_info", int'(sq_info), 0);
    chk("rst_sq_err", int'(sq_err), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: one state record per driven cycle; squash data popped on valid.
  initial begin
    rec_t          r;
    logic [IW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rec_q.size() > 0) begin
        r = rec_q.pop_front();
        chk("count", int'(count), r.cnt);
        chk("enq_idx", int'(enq_idx), r.idx);
        chk("enq_ready", int'(enq_ready), int'(r.rdy));
        chk("sq_err", int'(sq_err), int'(r.err));
        chk("sq_info_valid", int'(sq_info_valid), int'(r.sqv));
`ifdef RAS_CKPT_PARITY_EN
        chk("sq_perr", int'(sq_perr), int'(r.perr));
`endif
        if (r.sqv && info_q.size() > 0) begin
          e = info_q.pop_front();
          if (sq_info_valid) chk("sq_info", int'(sq_info), int'(e));
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int off, si;
    bit ev, sv, cv;
    m_head = 0;
    m_tail = 0;
    m_err  = 1'b0;
    for (int i = 0; i < D; i++) m_flip[i] = 1'b0;
    repeat (2) @(negedge clk);
    reset_dut();

    // Three entries A, B, C.
    enq(16'hA0A1);
    enq(16'hB0B1);
    enq(16'hC0C1);
    idle();
    settle();
    chk("abc_count", int'(count), 3);

    // Fill to full, overflow attempt, then one commit.
    reset_dut();
    for (int i = 0; i < D; i++) enq(IW'($urandom));
    enq(16'hDEAD);
    cyc(1'b0, '0, 1'b0, 0, 1'b1);
    idle();
    settle();
    chk("full_then_commit_enq_idx", int'(enq_idx), 32);

    // Squash into the middle of five entries.
    reset_dut();
    for (int i = 0; i < 5; i++) enq(IW'($urandom));
    cyc(1'b0, '0, 1'b1, 2, 1'b0);
    idle();
    idle();
    settle();
    chk("sq_mid_count", int'(count), 3);

    // Squash, enqueue and commit together at the head.
    reset_dut();
    for (int i = 0; i < 4; i++) enq(IW'($urandom));
    cyc(1'b1, 16'h5555, 1'b1, 0, 1'b1);
    idle();
    settle();
    chk("sim_count", int'(count), 0);
    chk("sim_tail", int'(enq_idx), 1);

    // Random traffic.
    reset_dut();
    for (int n = 0; n < 1500; n++) begin
      ev = ($urandom_range(0, 9) < 6);
      cv = ($urandom_range(0, 9) < 3);
      sv = 1'b0;
      si = 0;
      if ($urandom_range(0, 11) == 0 && mcnt() > 0) begin
        sv  = 1'b1;
        off = $urandom_range(0, mcnt() - 1);
        si  = (m_head + off) % (2 * D);
      end else if ($urandom_range(0, 99) == 0) begin
        sv = 1'b1;
        si = $urandom_range(0, 2 * D - 1);
      end
      cyc(ev, IW'($urandom), sv, si, cv);
    end
    idle();

    // Wrap-around: head={0,30}, tail={1,2}.
    reset_dut();
    for (int i = 0; i < 30; i++) enq(IW'($urandom));
    for (int i = 0; i < 30; i++) cyc(1'b0, '0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 4; i++) enq(IW'($urandom));
    cyc(1'b0, '0, 1'b1, 32, 1'b0);
    cyc(1'b0, '0, 1'b1, 5, 1'b0);
    idle();
    settle();
    chk("wrap_tail", int'(enq_idx), 33);
    chk("wrap_sq_err", int'(sq_err), 1);

    // Reset while a squash pulse is in flight.
    reset_dut();
    for (int i = 0; i < 3; i++) enq(IW'($urandom));
    cyc(1'b0, '0, 1'b1, 1, 1'b0);
    settle();
    rst = 1'b1;
    enq_valid = 1'b0;
    sq_valid  = 1'b0;
    cm_valid  = 1'b0;
    m_head = 0;
    m_tail = 0;
    m_err  = 1'b0;
    #1;
    chk("midrst_sq_info_valid", int'(sq_info_valid), 0);
    chk("midrst_count", int'(count), 0);
    @(negedge clk);
    rst = 1'b0;

`ifdef RAS_CKPT_PARITY_EN
    // Corrupted entry 1 reports a parity error; a clean one does not.
    reset_dut();
    for (int i = 0; i < 3; i++) enq(IW'($urandom));
    idle();
    dut.u_mem.mem_q[1][0] = ~dut.u_mem.mem_q[1][0];
    m_mem[1][0] = ~m_mem[1][0];
    m_flip[1]   = 1'b1;
    cyc(1'b0, '0, 1'b1, 1, 1'b0);
    idle();
    reset_dut();
    for (int i = 0; i < 3; i++) enq(IW'($urandom));
    idle();
    cyc(1'b0, '0, 1'b1, 1, 1'b0);
    idle();
`endif

    settle();
    chk("scoreboard_drained", info_q.size() + rec_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
